ctrl_pipeline: RTL and testbench

Pipelined control unit for the 5-stage RV32 core. It decodes the instruction held in IF/ID into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards and stalls for them, flushes on taken branches and jumps, and drives the EX-stage forwarding selects. It sits between the IF/ID register and the datapath and replaces the purely combinational opcode decoder.

---
 rtl/ctrl_pipeline.sv | 218 +++++++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: pipelined control unit for the 5-stage RV32 core.
// Decodes the IF/ID instruction into a control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards,
// handles flushes on redirect, and drives the EX-stage forwarding selects.
//
// Optional feature macro: ILLEGAL_TRAP_EN (adds registered output illegal_o).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   id_inst, id_valid     instruction held in IF/ID and its valid flag
//   ex_redirect           branch taken / jump resolved in EX this cycle
//   pc_write, ifid_write  combinational: PC / IF/ID may update (low on stall)
//   ifid_flush            combinational: clear IF/ID to a bubble
//   ex_*                  registered EX-stage control and register indices
//   fwd_a, fwd_b          combinational forwarding selects (00 RF, 01 WB, 10 MEM)
//   mem_*                 registered MEM-stage control
//   wb_*                  registered WB-stage control
//   stall_count           saturating count of load-use stall cycles
//   illegal_o             (ILLEGAL_TRAP_EN only) unknown opcode seen, EX-aligned
module ctrl_pipeline #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            id_inst,
  input  logic                   id_valid,
  input  logic                   ex_redirect,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   ex_valid,
  output logic                   ex_branch,
  output logic                   ex_jump,
  output logic                   ex_alusrc,
  output logic [1:0]             ex_aluop,
  output logic [REG_AW-1:0]      ex_rs1,
  output logic [REG_AW-1:0]      ex_rs2,
  output logic [REG_AW-1:0]      ex_rd,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   mem_valid,
  output logic                   mem_memread,
  output logic                   mem_memwrite,
  output logic [REG_AW-1:0]      mem_rd,
  output logic                   wb_valid,
  output logic                   wb_regwrite,
  output logic [1:0]             wb_sel,
  output logic [REG_AW-1:0]      wb_rd,
  output logic [STALL_CNT_W-1:0] stall_count
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                   illegal_o
`endif
);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              jump;
    logic              alusrc;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic [1:0]        aluop;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  idex_t  dec;
  idex_t  ex_q;
  exmem_t mem_q;
  memwb_t wb_q;
  logic   known;
  logic   use_rs1;
  logic   use_rs2;
  logic   load_use;
  logic   stall;
  logic   unused_inst;

  // Only opcode and register fields are consumed here.
  assign unused_inst = ^id_inst;

  // Opcode decode; unused register fields and non-writing rd are zeroed.
  always_comb begin
    dec     = '0;
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (id_inst[6:2])
      OP_R:      begin dec.regwrite = 1'b1; dec.aluop = 2'b10; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IALU:   begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11; use_rs1 = 1'b1; end
      OP_LOAD:   begin dec.memread = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
                       dec.wb_sel = 2'b01; use_rs1 = 1'b1; end
      OP_STORE:  begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRANCH: begin dec.branch = 1'b1; dec.aluop = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL:    begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.wb_sel = 2'b10; end
      OP_JALR:   begin dec.jump = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
                       dec.wb_sel = 2'b10; use_rs1 = 1'b1; end
      OP_LUI:    begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      default:   known = 1'b0;
    endcase
    dec.rs1 = use_rs1 ? id_inst[15 +: REG_AW] : '0;
    dec.rs2 = use_rs2 ? id_inst[20 +: REG_AW] : '0;
    dec.rd  = dec.regwrite ? id_inst[7 +: REG_AW] : '0;
    dec.valid = 1'b1;
    if (!(id_valid && known)) begin
      dec = '0;
    end
  end

  // Load-use hazard; dec.rs* are zero when unused and ex rd must be nonzero.
  assign load_use = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                    ((ex_q.rd == dec.rs1) | (ex_q.rd == dec.rs2));
  // A redirect kills the ID instruction, so it overrides the stall.
  assign stall      = load_use & ~ex_redirect;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign ifid_flush = ex_redirect;

  // Pipeline registers; only ID/EX sees stalls and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= (stall || ex_redirect) ? idex_t'('0) : dec;
      mem_q <= '{valid: ex_q.valid, memread: ex_q.memread, memwrite: ex_q.memwrite,
                 regwrite: ex_q.regwrite, wb_sel: ex_q.wb_sel, rd: ex_q.rd};
      wb_q  <= '{valid: mem_q.valid, regwrite: mem_q.regwrite,
                 wb_sel: mem_q.wb_sel, rd: mem_q.rd};
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Flags an unknown opcode alongside the bubble it becomes in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= id_valid & ~known & ~ex_redirect;
    end
  end
`endif

  // Forwarding: MEM result wins over WB result.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_q.valid && mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1)) begin
      fwd_a = 2'b10;
    end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs1)) begin
      fwd_a = 2'b01;
    end
    if (mem_q.valid && mem_q.regwrite && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2)) begin
      fwd_b = 2'b10;
    end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs2)) begin
      fwd_b = 2'b01;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_aluop     = ex_q.aluop;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign mem_valid    = mem_q.valid;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_rd       = mem_q.rd;
  assign wb_valid     = wb_q.valid;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_sel       = wb_q.wb_sel;
  assign wb_rd        = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// stage-list behavioural model.
module tb_ctrl_pipeline;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned SCW     = 3;
  localparam int          CNT_MAX = (1 << SCW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       id_inst = '0;
  logic              id_valid = 1'b0;
  logic              ex_redirect = 1'b0;
  logic              pc_write, ifid_write, ifid_flush;
  logic              ex_valid, ex_branch, ex_jump, ex_alusrc;
  logic [1:0]        ex_aluop, fwd_a, fwd_b, wb_sel;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              mem_valid, mem_memread, mem_memwrite, wb_valid, wb_regwrite;
  logic [SCW-1:0]    stall_count;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_o;
  bit                m_ill;
`endif

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  ctrl_pipeline #(.REG_AW(REG_AW), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_sel(wb_sel), .wb_rd(wb_rd), .stall_count(stall_count)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  always #5 clk = ~clk;

  // One instruction's control bundle as the model sees it.
  typedef struct {
    bit       valid, branch, jump, alusrc, memread, memwrite, regwrite, illegal;
    bit [1:0] aluop, wb_sel;
    bit [4:0] rs1, rs2, rd;
  } ctl_t;

  ctl_t m_ex, m_mem, m_wb;
  int   m_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t bubble();
    ctl_t c = '{default: 0};
    return c;
  endfunction

  // Instruction kind -> control bundle, from the opcode table.
  function automatic ctl_t decode(input logic [31:0] inst, input logic v);
    ctl_t c = '{default: 0};
    bit u1 = 0, u2 = 0;
    if (!v) return c;
    case (inst[6:2])
      5'b01100: begin c.regwrite = 1; c.aluop = 2; u1 = 1; u2 = 1; end
      5'b00100: begin c.alusrc = 1; c.regwrite = 1; c.aluop = 3; u1 = 1; end
      5'b00000: begin c.memread = 1; c.alusrc = 1; c.regwrite = 1; c.wb_sel = 1; u1 = 1; end
      5'b01000: begin c.memwrite = 1; c.alusrc = 1; u1 = 1; u2 = 1; end
      5'b11000: begin c.branch = 1; c.aluop = 1; u1 = 1; u2 = 1; end
      5'b11011: begin c.jump = 1; c.regwrite = 1; c.wb_sel = 2; end
      5'b11001: begin c.jump = 1; c.alusrc = 1; c.regwrite = 1; c.wb_sel = 2; u1 = 1; end
      5'b01101: begin c.alusrc = 1; c.regwrite = 1; end
      default:  c.illegal = 1;
    endcase
    if (!c.illegal) begin
      c.valid = 1;
      c.rs1 = u1 ? inst[19:15] : 5'd0;
      c.rs2 = u2 ? inst[24:20] : 5'd0;
      c.rd  = c.regwrite ? inst[11:7] : 5'd0;
    end
    return c;
  endfunction

  function automatic bit exp_stall();
    ctl_t d = decode(id_inst, id_valid);
    bit lu = id_valid && m_ex.valid && m_ex.memread && (m_ex.rd != 0) &&
             ((m_ex.rd == d.rs1) || (m_ex.rd == d.rs2));
    return lu && !ex_redirect;
  endfunction

  function automatic ctl_t next_ex();
    ctl_t d = decode(id_inst, id_valid);
    if (ex_redirect || exp_stall() || d.illegal) return bubble();
    return d;
  endfunction

  function automatic bit is_illegal();
    ctl_t d = decode(id_inst, id_valid);
    return d.illegal;
  endfunction

  function automatic int exp_fwd(input bit [4:0] rs);
    if (m_mem.valid && m_mem.regwrite && m_mem.rd != 0 && m_mem.rd == rs) return 2;
    if (m_wb.valid && m_wb.regwrite && m_wb.rd != 0 && m_wb.rd == rs) return 1;
    return 0;
  endfunction

  // Model: a list of three stage slots that shift every edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  <= bubble();
      m_mem <= bubble();
      m_wb  <= bubble();
      m_cnt <= 0;
`ifdef ILLEGAL_TRAP_EN
      m_ill <= 0;
`endif
    end else begin
      m_ex  <= next_ex();
      m_mem <= m_ex;
      m_wb  <= m_mem;
      if (exp_stall()) m_cnt <= (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
`ifdef ILLEGAL_TRAP_EN
      m_ill <= is_illegal() && !ex_redirect;
`endif
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_write",    int'(pc_write),    int'(!exp_stall()));
      check("ifid_write",  int'(ifid_write),  int'(!exp_stall()));
      check("ifid_flush",  int'(ifid_flush),  int'(ex_redirect));
      check("fwd_a",       int'(fwd_a),       exp_fwd(m_ex.rs1));
      check("fwd_b",       int'(fwd_b),       exp_fwd(m_ex.rs2));
      check("ex_valid",    int'(ex_valid),    int'(m_ex.valid));
      check("ex_branch",   int'(ex_branch),   int'(m_ex.branch));
      check("ex_jump",     int'(ex_jump),     int'(m_ex.jump));
      check("ex_alusrc",   int'(ex_alusrc),   int'(m_ex.alusrc));
      check("ex_aluop",    int'(ex_aluop),    int'(m_ex.aluop));
      if (m_ex.valid) begin
        check("ex_rs1", int'(ex_rs1), int'(m_ex.rs1));
        check("ex_rs2", int'(ex_rs2), int'(m_ex.rs2));
      end
      if (m_ex.regwrite) check("ex_rd", int'(ex_rd), int'(m_ex.rd));
      check("mem_valid",    int'(mem_valid),    int'(m_mem.valid));
      check("mem_memread",  int'(mem_memread),  int'(m_mem.memread));
      check("mem_memwrite", int'(mem_memwrite), int'(m_mem.memwrite));
      if (m_mem.regwrite) check("mem_rd", int'(mem_rd), int'(m_mem.rd));
      check("wb_valid",    int'(wb_valid),    int'(m_wb.valid));
      check("wb_regwrite", int'(wb_regwrite), int'(m_wb.regwrite));
      check("wb_sel",      int'(wb_sel),      int'(m_wb.wb_sel));
      if (m_wb.regwrite) check("wb_rd", int'(wb_rd), int'(m_wb.rd));
      check("stall_count", int'(stall_count), m_cnt);
`ifdef ILLEGAL_TRAP_EN
      check("illegal_o", int'(illegal_o), int'(m_ill));
`endif
    end
  end

  function automatic logic [31:0] r_type(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  // Present one IF/ID value for the next cycle.
  task automatic issue(input logic [31:0] inst, input logic v, input logic redir);
    @(posedge clk);
    #1;
    id_inst     = inst;
    id_valid    = v;
    ex_redirect = redir;
  endtask

  task automatic idle();
    issue(32'd0, 1'b0, 1'b0);
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0001111};

  initial begin
    logic [31:0] inst;
    chk_en = 1'b1;
    #12;
    check("rst ex_valid", int'(ex_valid), 0);
    check("rst wb_regwrite", int'(wb_regwrite), 0);
    check("rst stall_count", int'(stall_count), 0);
    check("rst pc_write", int'(pc_write), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // add x3,x1,x2 then idle
    issue(r_type(3, 1, 2), 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("add ex_aluop", int'(ex_aluop), 2);
    check("add ex_valid", int'(ex_valid), 1);
    idle();
    idle();
    @(negedge clk);
    check("add wb_regwrite", int'(wb_regwrite), 1);
    check("add wb_rd", int'(wb_rd), 3);
    check("add wb_sel", int'(wb_sel), 0);

    // lw x5,0(x1) ; add x6,x5,x7 -> one stall then WB forward
    issue(lw(5, 1), 1'b1, 1'b0);
    issue(r_type(6, 5, 7), 1'b1, 1'b0);
    @(negedge clk);
    check("lu pc_write", int'(pc_write), 0);
    check("lu ifid_write", int'(ifid_write), 0);
    issue(r_type(6, 5, 7), 1'b1, 1'b0);
    @(negedge clk);
    check("lu ex bubble", int'(ex_valid), 0);
    check("lu stall_count", int'(stall_count), 1);
    check("lu pc_write after", int'(pc_write), 1);
    idle();
    @(negedge clk);
    check("lu ex_rs1", int'(ex_rs1), 5);
    check("lu fwd_a", int'(fwd_a), 1);

    // add x4 ; sub x8,x4,x4 -> MEM forward on both operands
    issue(r_type(4, 1, 2), 1'b1, 1'b0);
    issue({7'b0100000, 5'd4, 5'd4, 3'd0, 5'd8, 7'b0110011}, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("mem fwd_a", int'(fwd_a), 2);
    check("mem fwd_b", int'(fwd_b), 2);
    issue(r_type(0, 1, 2), 1'b1, 1'b0);
    issue(r_type(8, 0, 0), 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("x0 fwd_a", int'(fwd_a), 0);
    check("x0 fwd_b", int'(fwd_b), 0);

    // redirect together with a load-use condition
    issue(lw(5, 1), 1'b1, 1'b0);
    issue(r_type(6, 5, 7), 1'b1, 1'b1);
    @(negedge clk);
    check("fl ifid_flush", int'(ifid_flush), 1);
    check("fl pc_write", int'(pc_write), 1);
    idle();
    @(negedge clk);
    check("fl ex bubble", int'(ex_valid), 0);
    check("fl stall_count", int'(stall_count), 1);

    // unknown opcode becomes a bubble
    issue(32'h0000_007f, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("ill ex_valid", int'(ex_valid), 0);
    check("ill ex_aluop", int'(ex_aluop), 0);
    check("ill ex_alusrc", int'(ex_alusrc), 0);
`ifdef ILLEGAL_TRAP_EN
    check("ill illegal_o", int'(illegal_o), 1);
    idle();
    @(negedge clk);
    check("ill illegal_o drop", int'(illegal_o), 0);
`endif

    // reset asserted mid-stall
    issue(lw(5, 1), 1'b1, 1'b0);
    issue(r_type(6, 5, 7), 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst ex_valid", int'(ex_valid), 0);
    check("mrst mem_valid", int'(mem_valid), 0);
    check("mrst wb_valid", int'(wb_valid), 0);
    check("mrst stall_count", int'(stall_count), 0);
    check("mrst pc_write", int'(pc_write), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      inst = $urandom;
      inst[6:0]   = ops[$urandom_range(0, 9)];
      inst[11:10] = 2'b00;
      inst[19:18] = 2'b00;
      inst[24:23] = 2'b00;
      issue(inst, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
